// File: rtl/rv32i_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_timer_ctrl_if
//  Purpose  : Bus request/response bundle for the RV32I machine-timer
//             register block (CLINT-style mtime/mtimecmp/msip access).
//  Signals  : wr_en    - write request
//             rd_en    - read request
//             addr     - byte offset into the register map (5 bits)
//             data_in  - write data
//             wr_mask  - byte enables for data_in
//             data_out - read data, valid in the ack cycle and held
//             ack      - one-cycle completion strobe
//  Modports : master (bus requester), slave (timer block)
//  Revision : 1.0 - initial release
// ============================================================================
interface rv32i_timer_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  wr_mask;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output wr_en, rd_en, addr, data_in, wr_mask,
        input  data_out, ack
    );

    modport slave (
        input  wr_en, rd_en, addr, data_in, wr_mask,
        output data_out, ack
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_timer_ctrl
//  Purpose  : Memory-mapped control of the core's mtime/mtimecmp registers
//             and the machine-software interrupt. 64-bit registers are
//             written as a staged LO word followed by a committing HI write,
//             which issues a single load pulse to the core. Reads of
//             MTIME_LO snapshot the upper half so a LO-then-HI read pair
//             is coherent.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             bus                 - request/response interface (slave)
//             mtime_cur           - live mtime from the core
//             mtime_wr/_din       - mtime load pulse and value
//             mtimecmp_wr/_din    - mtimecmp load pulse and value
//             software_interrupt  - level MSIP interrupt
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_timer_ctrl #(
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    rv32i_timer_ctrl_if.slave      bus,
    input  wire logic [63:0]       mtime_cur,
    output logic                   mtime_wr,
    output logic                   mtimecmp_wr,
    output logic [63:0]            mtime_din,
    output logic [63:0]            mtimecmp_din,
    output logic                   software_interrupt
);

    // Word indices of the register map (addr[4:2])
    localparam logic [2:0] C_MTIME_LO    = 3'd0;
    localparam logic [2:0] C_MTIME_HI    = 3'd1;
    localparam logic [2:0] C_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] C_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] C_MSIP        = 3'd4;

    // Post-reset sequencer: INIT pushes CMP_RESET to the core once
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_IDLE = 1'b1;

    logic [0:0]  r_state;
    logic        r_ack;
    logic [31:0] r_data_out;
    logic [31:0] r_mt_stage;     // staged MTIME_LO
    logic [31:0] r_cmp_stage;    // staged MTIMECMP_LO
    logic        r_mt_pend;
    logic        r_cmp_pend;
    logic [31:0] r_mt_clo;       // committed low words; cleared by reset
    logic [31:0] r_cmp_clo;      // independently of the *_din reset value
    logic [31:0] r_snap_hi;      // mtime[63:32] captured on MTIME_LO read

    // Byte-lane merge of bus write data into an existing word
    function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_rd;
    logic        w_mask_any;
    logic [63:0] w_mt_commit;
    logic [63:0] w_cmp_commit;
    logic [1:0]  w_unused_addr;

    assign w_idx         = bus.addr[4:2];
    assign w_unused_addr = bus.addr[1:0];
    assign w_wr          = bus.wr_en;
    // A combined read+write request is serviced as a write only
    assign w_rd          = bus.rd_en & ~bus.wr_en;
    assign w_mask_any    = |bus.wr_mask;

    // HI commit value: merged high word over the staged low if one is
    // pending, otherwise the previously committed low
    assign w_mt_commit  = {f_merge(mtime_din[63:32], bus.data_in, bus.wr_mask),
                           r_mt_pend ? r_mt_stage : r_mt_clo};
    assign w_cmp_commit = {f_merge(mtimecmp_din[63:32], bus.data_in, bus.wr_mask),
                           r_cmp_pend ? r_cmp_stage : r_cmp_clo};

    assign bus.ack      = r_ack;
    assign bus.data_out = r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_INIT;
            r_ack              <= 1'b0;
            r_data_out         <= 32'd0;
            r_mt_stage         <= 32'd0;
            r_cmp_stage        <= 32'd0;
            r_mt_pend          <= 1'b0;
            r_cmp_pend         <= 1'b0;
            r_mt_clo           <= 32'd0;
            r_cmp_clo          <= 32'd0;
            r_snap_hi          <= 32'd0;
            mtime_wr           <= 1'b0;
            mtimecmp_wr        <= 1'b0;
            mtime_din          <= 64'd0;
            mtimecmp_din       <= CMP_RESET;
            software_interrupt <= 1'b0;
        end else begin
            r_state     <= S_IDLE;
            r_ack       <= bus.wr_en | bus.rd_en;
            mtime_wr    <= 1'b0;
            mtimecmp_wr <= (r_state == S_INIT);
            if (r_state == S_INIT) begin
                mtimecmp_din <= CMP_RESET;
            end

            // A colliding MTIMECMP_HI commit below overrides the INIT value
            if (w_wr && w_mask_any) begin
                case (w_idx)
                    C_MTIME_LO: begin
                        r_mt_stage <= f_merge(r_mt_stage, bus.data_in, bus.wr_mask);
                        r_mt_pend  <= 1'b1;
                    end
                    C_MTIME_HI: begin
                        mtime_din <= w_mt_commit;
                        r_mt_clo  <= w_mt_commit[31:0];
                        r_mt_pend <= 1'b0;
                        mtime_wr  <= 1'b1;
                    end
                    C_MTIMECMP_LO: begin
                        r_cmp_stage <= f_merge(r_cmp_stage, bus.data_in, bus.wr_mask);
                        r_cmp_pend  <= 1'b1;
                    end
                    C_MTIMECMP_HI: begin
                        mtimecmp_din <= w_cmp_commit;
                        r_cmp_clo    <= w_cmp_commit[31:0];
                        r_cmp_pend   <= 1'b0;
                        mtimecmp_wr  <= 1'b1;
                    end
                    C_MSIP: begin
                        if (bus.wr_mask[0]) software_interrupt <= bus.data_in[0];
                    end
                    default: ;
                endcase
            end else if (w_rd) begin
                case (w_idx)
                    C_MTIME_LO: begin
                        r_data_out <= mtime_cur[31:0];
                        r_snap_hi  <= mtime_cur[63:32];
                    end
                    C_MTIME_HI:    r_data_out <= r_snap_hi;
                    C_MTIMECMP_LO: r_data_out <= mtimecmp_din[31:0];
                    C_MTIMECMP_HI: r_data_out <= mtimecmp_din[63:32];
                    C_MSIP:        r_data_out <= {31'd0, software_interrupt};
                    default:       r_data_out <= 32'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_timer_ctrl
//  Purpose  : Self-checking bench for rv32i_timer_ctrl. Directed register-map
//             scenarios followed by randomized bus traffic, all checked
//             against a register-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_timer_ctrl;

    localparam logic [63:0] C_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] mtime_cur;
    logic        mtime_wr;
    logic        mtimecmp_wr;
    logic [63:0] mtime_din;
    logic [63:0] mtimecmp_din;
    logic        software_interrupt;

    rv32i_timer_ctrl_if bus();

    rv32i_timer_ctrl #(.CMP_RESET(C_CMP_RESET)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus.slave),
        .mtime_cur          (mtime_cur),
        .mtime_wr           (mtime_wr),
        .mtimecmp_wr        (mtimecmp_wr),
        .mtime_din          (mtime_din),
        .mtimecmp_din       (mtimecmp_din),
        .software_interrupt (software_interrupt)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 = mtime, index 1 = mtimecmp
    logic [31:0] m_stage [2];
    logic [31:0] m_clo   [2];
    logic        m_pend  [2];
    logic [63:0] m_din   [2];
    logic        m_pulse [2];
    logic        m_ack;
    logic        m_sw;
    logic        m_init;
    logic [31:0] m_dout;
    logic [31:0] m_snap;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old_w, input logic [31:0] d,
                                           input logic [3:0] m);
        return (old_w & ~lane_mask(m)) | (d & lane_mask(m));
    endfunction

    task automatic check_all(input string ctx);
        chk({ctx, " ack"},          64'(bus.ack),            64'(m_ack));
        chk({ctx, " mtime_wr"},     64'(mtime_wr),           64'(m_pulse[0]));
        chk({ctx, " mtimecmp_wr"},  64'(mtimecmp_wr),        64'(m_pulse[1]));
        chk({ctx, " mtime_din"},    mtime_din,               m_din[0]);
        chk({ctx, " mtimecmp_din"}, mtimecmp_din,            m_din[1]);
        chk({ctx, " data_out"},     64'(bus.data_out),       64'(m_dout));
        chk({ctx, " sw_int"},       64'(software_interrupt), 64'(m_sw));
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_stage[r] = '0; m_clo[r] = '0; m_pend[r] = 1'b0; m_pulse[r] = 1'b0;
        end
        m_din[0] = 64'd0;
        m_din[1] = C_CMP_RESET;
        m_ack = 1'b0; m_sw = 1'b0; m_dout = '0; m_snap = '0;
        m_init = 1'b1;
    endtask

    task automatic model_apply(input logic wr, input logic rd, input logic [4:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               input logic [63:0] cur);
        int word;
        int r;
        logic [31:0] lo;
        word = int'(a) / 4;
        m_ack = wr | rd;
        m_pulse[0] = 1'b0;
        m_pulse[1] = 1'b0;
        if (m_init) begin
            m_pulse[1] = 1'b1;
            m_din[1]   = C_CMP_RESET;
            m_init     = 1'b0;
        end
        if (wr) begin
            if (m != 4'd0) begin
                if (word < 4) begin
                    r = word / 2;
                    if (word % 2 == 0) begin
                        m_stage[r] = merged(m_stage[r], d, m);
                        m_pend[r]  = 1'b1;
                    end else begin
                        lo         = m_pend[r] ? m_stage[r] : m_clo[r];
                        m_din[r]   = {merged(m_din[r][63:32], d, m), lo};
                        m_clo[r]   = lo;
                        m_pend[r]  = 1'b0;
                        m_pulse[r] = 1'b1;
                    end
                end else if (word == 4 && m[0]) begin
                    m_sw = d[0];
                end
            end
        end else if (rd) begin
            case (word)
                0: begin m_dout = cur[31:0]; m_snap = cur[63:32]; end
                1: m_dout = m_snap;
                2: m_dout = m_din[1][31:0];
                3: m_dout = m_din[1][63:32];
                4: m_dout = {31'd0, m_sw};
                default: m_dout = 32'd0;
            endcase
        end
    endtask

    task automatic step(input logic wr, input logic rd, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic [63:0] cur, input string ctx);
        bus.wr_en = wr; bus.rd_en = rd; bus.addr = a;
        bus.data_in = d; bus.wr_mask = m; mtime_cur = cur;
        @(posedge clk);
        #1;
        model_apply(wr, rd, a, d, m, cur);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx);
        step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, mtime_cur, ctx);
    endtask

    // Requests are driven throughout reset and must be ignored
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = 1'($urandom);
            bus.addr    = 5'($urandom);
            bus.data_in = $urandom;
            bus.wr_mask = 4'hF;
            @(posedge clk);
            #1;
            model_reset();
            check_all("reset");
        end
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_mask = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        mtime_cur = 64'd0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 5'd0;
        bus.data_in = 32'd0; bus.wr_mask = 4'd0;
        model_reset();

        // Post-reset push, then an idle cycle with no pulse or ack
        do_reset(3);
        idle("post_reset_push");
        idle("post_reset_quiet");

        // HI-only write straight after reset
        step(1, 0, 5'h04, 32'h0000_0001, 4'hF, 64'd0, "hi_only");

        // mtimecmp commit
        step(1, 0, 5'h08, 32'h0000_000F, 4'hF, 64'd0, "cmp_lo");
        step(1, 0, 5'h0C, 32'h0000_0000, 4'hF, 64'd0, "cmp_hi");

        // Partial-mask LO then HI
        step(1, 0, 5'h00, 32'hAABB_CCDD, 4'b0011, 64'd0, "part_lo");
        step(1, 0, 5'h04, 32'h0000_0000, 4'hF,    64'd0, "part_hi");

        // Independent registers, commits in back-to-back cycles
        step(1, 0, 5'h00, 32'h1111_2222, 4'hF, 64'd0, "both_mt_lo");
        step(1, 0, 5'h08, 32'h3333_4444, 4'hF, 64'd0, "both_cmp_lo");
        step(1, 0, 5'h04, 32'h5555_6666, 4'hF, 64'd0, "both_mt_hi");
        step(1, 0, 5'h0C, 32'h7777_8888, 4'hF, 64'd0, "both_cmp_hi");

        // Coherent LO/HI read
        step(0, 1, 5'h00, 32'd0, 4'd0, 64'h0000_0001_FFFF_FFFF, "coh_lo");
        step(0, 1, 5'h04, 32'd0, 4'd0, 64'h0000_0002_0000_0000, "coh_hi");

        // Combined read+write is a write; data_out held
        step(1, 1, 5'h10, 32'h0000_0001, 4'h1, 64'd0, "rw_both");
        step(0, 1, 5'h08, 32'd0, 4'd0, 64'd0, "rd_cmp_lo");
        step(0, 1, 5'h0C, 32'd0, 4'd0, 64'd0, "rd_cmp_hi");
        step(0, 1, 5'h10, 32'd0, 4'd0, 64'd0, "rd_msip");
        step(0, 1, 5'h17, 32'd0, 4'd0, 64'd0, "rd_unmapped");

        // Zero-mask writes do nothing; low address bits ignored
        step(1, 0, 5'h00, 32'hDEAD_BEEF, 4'd0, 64'd0, "zmask_lo");
        step(1, 0, 5'h04, 32'hDEAD_BEEF, 4'd0, 64'd0, "zmask_hi");
        step(1, 0, 5'h0B, 32'h0BAD_F00D, 4'hF, 64'd0, "lowbits_lo");
        step(1, 0, 5'h0E, 32'h0000_00A5, 4'b0001, 64'd0, "lowbits_hi");
        step(1, 0, 5'h18, 32'hFFFF_FFFF, 4'hF, 64'd0, "wr_unmapped");

        // MSIP, then mid-sequence reset drops the staged LO
        step(1, 0, 5'h10, 32'h0000_0000, 4'h1, 64'd0, "msip_clr");
        step(1, 0, 5'h10, 32'h0000_0001, 4'hF, 64'd0, "msip_set");
        step(1, 0, 5'h08, 32'h0000_0005, 4'hF, 64'd0, "stage5");
        do_reset(2);
        idle("rst2_push");
        step(1, 0, 5'h0C, 32'h0000_0000, 4'hF, 64'd0, "stage_dropped");

        // Commit colliding with the post-reset push
        do_reset(1);
        step(1, 0, 5'h0C, 32'h1234_5678, 4'b0101, 64'd0, "init_collide");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic        wr, rd;
            logic [4:0]  a;
            logic [3:0]  m;
            if (i % 100 == 99) begin
                do_reset(1 + int'($urandom_range(0, 2)));
            end
            wr = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4) * 4);
            m  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step(wr, rd, a, $urandom, m, {$urandom, $urandom}, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
